// File: rtl/scan_seq_ctrl_if.sv
// Control, pattern-stream, scan-chain and status bundle for scan_seq_ctrl.
// master = test-mode side driving the stream; slave = the sequencer.
interface scan_seq_ctrl_if #(
   parameter int NCHAIN    = 4,
   parameter int CHAIN_LEN = 64,
   parameter int NPAT_W    = 16
);
   localparam int VW = $clog2(CHAIN_LEN);

   logic              start;
   logic              abort;
   logic [NPAT_W-1:0] npat;
   logic              pat_valid;
   logic              pat_ready;
   logic [NCHAIN-1:0] pat_si;
   logic [NCHAIN-1:0] pat_exp;
   logic [NCHAIN-1:0] pat_msk;
   logic [NCHAIN-1:0] chain_so;
   logic [NCHAIN-1:0] chain_si;
   logic              se;
   logic              shift_en;
   logic              cap_en;
   logic              busy;
   logic              done;
   logic [15:0]       fail_cnt;
   logic [NPAT_W-1:0] ff_pat;
   logic [VW-1:0]     ff_vec;
   logic              ff_vld;

   modport master (
      output start, abort, npat, pat_valid, pat_si, pat_exp, pat_msk, chain_so,
      input  pat_ready, chain_si, se, shift_en, cap_en, busy, done,
             fail_cnt, ff_pat, ff_vec, ff_vld
   );

   modport slave (
      input  start, abort, npat, pat_valid, pat_si, pat_exp, pat_msk, chain_so,
      output pat_ready, chain_si, se, shift_en, cap_en, busy, done,
             fail_cnt, ff_pat, ff_vec, ff_vld
   );
endinterface

// File: rtl/scan_seq_ctrl.sv
// Scan load/unload sequencer: streams NCHAIN-wide beats into the chains, pulses capture,
// and compares the unloaded chain tails against masked expected data.
module scan_seq_ctrl #(
   parameter int NCHAIN    = 4,
   parameter int CHAIN_LEN = 64,
   parameter int CAP_CYC   = 1,
   parameter int SE_GAP    = 2,
   parameter int NPAT_W    = 16
) (
   input  logic          i_clk,
   input  logic          i_rstz,
   scan_seq_ctrl_if.slave io_scan
);
   localparam int             VW       = $clog2(CHAIN_LEN);
   localparam logic [VW-1:0]  V_LAST   = VW'(CHAIN_LEN - 1);
   localparam logic [2:0]     GAP_LAST = 3'((SE_GAP > 0) ? SE_GAP - 1 : 0);
   localparam logic [2:0]     CAP_LAST = 3'(CAP_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SHIFT, S_PRE_CAP, S_CAPTURE, S_POST_CAP, S_DONE
   } state_t;

   state_t            r_state, w_next;
   logic [NPAT_W-1:0] r_npat, r_pidx;
   logic [VW-1:0]     r_vidx;
   logic [2:0]        r_cnt;
   logic [NCHAIN-1:0] r_si;
   logic [15:0]       r_fail_cnt;
   logic [NPAT_W-1:0] r_ff_pat;
   logic [VW-1:0]     r_ff_vec;
   logic              r_ff_vld;

   logic              w_arm, w_shift, w_pidx_inc;
   logic [NCHAIN-1:0] w_mism;
   logic [5:0]        w_pop;
   logic [16:0]       w_sum;

   assign w_arm      = io_scan.start && !io_scan.abort && (r_state == S_IDLE || r_state == S_DONE);
   assign w_shift    = (r_state == S_SHIFT) && io_scan.pat_valid;
   assign w_pidx_inc = (w_next == S_SHIFT) && (r_state == S_CAPTURE || r_state == S_POST_CAP);
   assign w_mism     = (io_scan.chain_so ^ io_scan.pat_exp) & io_scan.pat_msk;
   assign w_sum      = {1'b0, r_fail_cnt} + {11'd0, w_pop};

   assign io_scan.shift_en = w_shift;
   assign io_scan.chain_si = w_shift ? io_scan.pat_si : r_si;
   assign io_scan.fail_cnt = r_fail_cnt;
   assign io_scan.ff_pat   = r_ff_pat;
   assign io_scan.ff_vec   = r_ff_vec;
   assign io_scan.ff_vld   = r_ff_vld;

   always_comb begin
      w_pop = '0;
      for (int unsigned i = 0; i < NCHAIN; i++) w_pop = w_pop + 6'(w_mism[i]);
   end

   always_ff @(posedge i_clk or negedge i_rstz) begin
      if (!i_rstz) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next            = r_state;
      io_scan.se        = 1'b0;
      io_scan.pat_ready = 1'b0;
      io_scan.cap_en    = 1'b0;
      io_scan.busy      = 1'b0;
      io_scan.done      = 1'b0;
      case (r_state)
         S_IDLE: if (w_arm) w_next = (io_scan.npat == '0) ? S_DONE : S_SHIFT;
         S_SHIFT: begin
            io_scan.se        = 1'b1;
            io_scan.pat_ready = 1'b1;
            io_scan.busy      = 1'b1;
            // the pass where r_pidx has caught up with npat only unloads
            if (w_shift && r_vidx == V_LAST) begin
               if (r_pidx == r_npat) w_next = S_DONE;
               else if (SE_GAP == 0) w_next = S_CAPTURE;
               else                  w_next = S_PRE_CAP;
            end
         end
         S_PRE_CAP: begin
            io_scan.busy = 1'b1;
            if (r_cnt == GAP_LAST) w_next = S_CAPTURE;
         end
         S_CAPTURE: begin
            io_scan.busy   = 1'b1;
            io_scan.cap_en = 1'b1;
            if (r_cnt == CAP_LAST) w_next = (SE_GAP == 0) ? S_SHIFT : S_POST_CAP;
         end
         S_POST_CAP: begin
            io_scan.busy = 1'b1;
            if (r_cnt == GAP_LAST) w_next = S_SHIFT;
         end
         S_DONE: begin
            io_scan.done = 1'b1;
            if (w_arm) w_next = (io_scan.npat == '0) ? S_DONE : S_SHIFT;
         end
         default: w_next = S_IDLE;
      endcase
      if (io_scan.abort) w_next = S_IDLE;
   end

   always_ff @(posedge i_clk or negedge i_rstz) begin
      if (!i_rstz) begin
         r_npat     <= '0;
         r_pidx     <= '0;
         r_vidx     <= '0;
         r_cnt      <= '0;
         r_si       <= '0;
         r_fail_cnt <= '0;
         r_ff_pat   <= '0;
         r_ff_vec   <= '0;
         r_ff_vld   <= 1'b0;
      end else begin
         if (r_state != w_next) r_cnt <= '0;
         else if (r_state inside {S_PRE_CAP, S_CAPTURE, S_POST_CAP}) r_cnt <= r_cnt + 3'd1;

         if (w_arm) begin
            r_npat     <= io_scan.npat;
            r_pidx     <= '0;
            r_vidx     <= '0;
            r_fail_cnt <= '0;
            r_ff_pat   <= '0;
            r_ff_vec   <= '0;
            r_ff_vld   <= 1'b0;
         end else begin
            if (w_pidx_inc) r_pidx <= r_pidx + 1'b1;
            if (w_shift) begin
               r_si   <= io_scan.pat_si;
               r_vidx <= (r_vidx == V_LAST) ? '0 : r_vidx + 1'b1;
               // pass 0 unloads whatever the chains held before the run
               if (r_pidx != '0) begin
                  r_fail_cnt <= w_sum[16] ? '1 : w_sum[15:0];
                  if (w_mism != '0 && !r_ff_vld) begin
                     r_ff_pat <= r_pidx - 1'b1;
                     r_ff_vec <= r_vidx;
                     r_ff_vld <= 1'b1;
                  end
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Scoreboard bench for scan_seq_ctrl: a behavioural chain model loops chain_si back to
// chain_so; expected beats and fail statistics come from the generated pattern stream.
`timescale 1ns/1ps
module tb_scan_seq_ctrl;
   localparam int NCHAIN    = 4;
   localparam int CHAIN_LEN = 8;
   localparam int CAP_CYC   = 1;
   localparam int SE_GAP    = 2;
   localparam int NPAT_W    = 16;
   localparam int VW        = $clog2(CHAIN_LEN);

   logic clk  = 1'b0;
   logic rstz = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [NCHAIN-1:0] sb[$];
   logic [NCHAIN-1:0] last_si = '0;
   logic [NCHAIN-1:0] r_cells [CHAIN_LEN];

   always #5 clk = ~clk;

   scan_seq_ctrl_if #(.NCHAIN(NCHAIN), .CHAIN_LEN(CHAIN_LEN), .NPAT_W(NPAT_W)) u_if ();

   scan_seq_ctrl #(
      .NCHAIN(NCHAIN), .CHAIN_LEN(CHAIN_LEN), .CAP_CYC(CAP_CYC),
      .SE_GAP(SE_GAP), .NPAT_W(NPAT_W)
   ) u_dut (
      .i_clk(clk),
      .i_rstz(rstz),
      .io_scan(u_if)
   );

   always @(posedge clk) begin
      if (!rstz) begin
         for (int i = 0; i < CHAIN_LEN; i++) r_cells[i] <= '0;
      end else if (u_if.shift_en) begin
         for (int i = CHAIN_LEN - 1; i > 0; i--) r_cells[i] <= r_cells[i-1];
         r_cells[0] <= u_if.chain_si;
      end
   end
   assign u_if.chain_so = r_cells[CHAIN_LEN-1];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [NCHAIN-1:0] inj_bits(input int mode, input int p, input int k);
      inj_bits = '0;
      if (mode == 1 && ((p == 1 && k == 5) || (p == 2 && k == 3))) inj_bits[2] = 1'b1;
      if (mode == 2 && p >= 1) inj_bits = '1;
   endfunction

   function automatic logic [15:0] sat16(input int v);
      return (v > 65535) ? 16'hFFFF : 16'(v);
   endfunction

   task automatic check_all_zero(input string tag);
      check_eq({tag, ":se"},        u_if.se, 0);
      check_eq({tag, ":pat_ready"}, u_if.pat_ready, 0);
      check_eq({tag, ":shift_en"},  u_if.shift_en, 0);
      check_eq({tag, ":cap_en"},    u_if.cap_en, 0);
      check_eq({tag, ":busy"},      u_if.busy, 0);
      check_eq({tag, ":done"},      u_if.done, 0);
      check_eq({tag, ":fail_cnt"},  u_if.fail_cnt, 0);
      check_eq({tag, ":ff_pat"},    u_if.ff_pat, 0);
      check_eq({tag, ":ff_vec"},    u_if.ff_vec, 0);
      check_eq({tag, ":ff_vld"},    u_if.ff_vld, 0);
      check_eq({tag, ":chain_si"},  u_if.chain_si, 0);
   endtask

   task automatic run_seq(input string name, input int npat_i, input logic [NCHAIN-1:0] msk,
                          input int inj_mode, input int gap_pct, input int abort_cap,
                          input int rst_beat, input bit busy_start);
      int nbeats, budget, b, pushed, caps, shifts, cyc, e_fail_i, p, k;
      logic [NCHAIN-1:0] ld[];
      logic [NCHAIN-1:0] e_si, m;
      logic              e_vld;
      logic [NPAT_W-1:0] e_pat;
      logic [VW-1:0]     e_vec;
      bit                fin, aborted, was_reset;
      nbeats = (npat_i + 1) * CHAIN_LEN;
      budget = 2 * nbeats + npat_i * (2 * SE_GAP + CAP_CYC + 2) + 100;
      b = 0; pushed = 0; caps = 0; shifts = 0; cyc = 0; e_fail_i = 0;
      e_vld = 1'b0; e_pat = '0; e_vec = '0;
      fin = 0; aborted = 0; was_reset = 0;
      ld = new[nbeats];
      foreach (ld[i]) ld[i] = NCHAIN'($urandom);
      sb.delete();

      @(posedge clk); #1;
      u_if.npat = NPAT_W'(npat_i);
      u_if.pat_msk = msk;
      u_if.pat_valid = 1'b0;
      u_if.start = 1'b1;
      while (!fin && cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
         u_if.start = 1'b0;
         if (busy_start && b == 10) begin
            u_if.npat  = '0;
            u_if.start = 1'b1;
         end
         if (b < nbeats) begin
            p = b / CHAIN_LEN;
            k = b % CHAIN_LEN;
            u_if.pat_valid = ($urandom_range(99) >= gap_pct);
            u_if.pat_si    = ld[b];
            u_if.pat_exp   = (p == 0) ? NCHAIN'($urandom) : (ld[b-CHAIN_LEN] ^ inj_bits(inj_mode, p, k));
            if (u_if.pat_valid && pushed == b) begin
               sb.push_back(ld[b]);
               pushed++;
            end
         end else begin
            u_if.pat_valid = 1'b0;
         end
         #1;
         if (abort_cap != 0 && u_if.cap_en && caps == abort_cap - 1) begin
            u_if.abort = 1'b1;
            aborted = 1;
         end
         if (rst_beat != 0 && b >= rst_beat && u_if.shift_en) begin
            check_eq({name, ":fail_before_rst"}, u_if.fail_cnt, sat16(e_fail_i));
            rstz = 1'b0;
            #1;
            check_all_zero({name, ":async_rst"});
            u_if.pat_valid = 1'b0;
            fin = 1;
            was_reset = 1;
         end else begin
            @(negedge clk);
            if (u_if.cap_en) begin
               caps++;
               check_eq({name, ":se_in_cap"}, u_if.se, 0);
               check_eq({name, ":shift_in_cap"}, u_if.shift_en, 0);
            end
            if (u_if.shift_en) begin
               check_eq({name, ":shift_valid"}, u_if.pat_valid, 1);
               if (sb.size() == 0) begin
                  check_eq({name, ":sb_empty"}, 32'(sb.size()), 1);
               end else begin
                  e_si = sb.pop_front();
                  check_eq({name, ":chain_si"}, u_if.chain_si, e_si);
                  last_si = e_si;
               end
               p = b / CHAIN_LEN;
               k = b % CHAIN_LEN;
               if (p >= 1) begin
                  m = inj_bits(inj_mode, p, k) & msk;
                  e_fail_i += $countones(m);
                  if (m != '0 && !e_vld) begin
                     e_vld = 1'b1;
                     e_pat = NPAT_W'(p - 1);
                     e_vec = VW'(k);
                  end
               end
               b++;
               shifts++;
            end else begin
               check_eq({name, ":chain_si_hold"}, u_if.chain_si, last_si);
            end
            if (aborted) begin
               @(posedge clk); #1;
               u_if.abort = 1'b0;
               u_if.pat_valid = 1'b0;
               @(negedge clk);
               check_eq({name, ":ab_se"},        u_if.se, 0);
               check_eq({name, ":ab_cap_en"},    u_if.cap_en, 0);
               check_eq({name, ":ab_pat_ready"}, u_if.pat_ready, 0);
               check_eq({name, ":ab_shift_en"},  u_if.shift_en, 0);
               check_eq({name, ":ab_busy"},      u_if.busy, 0);
               check_eq({name, ":ab_done"},      u_if.done, 0);
               check_eq({name, ":ab_fail_cnt"},  u_if.fail_cnt, sat16(e_fail_i));
               check_eq({name, ":ab_ff_vld"},    u_if.ff_vld, e_vld);
               check_eq({name, ":ab_ff_vec"},    u_if.ff_vec, e_vec);
               fin = 1;
            end else if (u_if.done) begin
               check_eq({name, ":done_at_last_beat"}, b, nbeats);
               fin = 1;
            end else begin
               check_eq({name, ":busy"}, u_if.busy, 1);
            end
         end
      end
      check_eq({name, ":finished"}, fin, 1);
      if (fin && !aborted && !was_reset) begin
         u_if.pat_valid = 1'b0;
         repeat (2) @(negedge clk);
         check_eq({name, ":done"},     u_if.done, 1);
         check_eq({name, ":busy_end"}, u_if.busy, 0);
         check_eq({name, ":se_end"},   u_if.se, 0);
         check_eq({name, ":beats"},    shifts, nbeats);
         check_eq({name, ":captures"}, caps, npat_i);
         check_eq({name, ":fail_cnt"}, u_if.fail_cnt, sat16(e_fail_i));
         check_eq({name, ":ff_vld"},   u_if.ff_vld, e_vld);
         check_eq({name, ":ff_pat"},   u_if.ff_pat, e_pat);
         check_eq({name, ":ff_vec"},   u_if.ff_vec, e_vec);
         check_eq({name, ":sb_left"},  32'(sb.size()), 0);
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      u_if.start = 1'b0;
      u_if.abort = 1'b0;
      u_if.npat = '0;
      u_if.pat_valid = 1'b0;
      u_if.pat_si = '0;
      u_if.pat_exp = '0;
      u_if.pat_msk = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rstz = 1'b1;

      run_seq("nominal",  2,    4'hF,    0, 0,  0, 0,  0);
      run_seq("inject",   2,    4'hF,    1, 0,  0, 0,  0);
      run_seq("masked",   2,    4'b1011, 1, 0,  0, 0,  0);
      run_seq("stall",    2,    4'hF,    0, 30, 0, 0,  1);
      run_seq("abort",    2,    4'hF,    1, 0,  2, 0,  0);
      run_seq("rerun",    2,    4'hF,    0, 0,  0, 0,  0);
      run_seq("rst_mid",  2,    4'hF,    2, 0,  0, 12, 0);
      @(negedge clk);
      rstz = 1'b1;
      last_si = '0;
      run_seq("saturate", 2200, 4'hF,    2, 0,  0, 0,  0);

      @(posedge clk); #1;
      u_if.npat = '0;
      u_if.start = 1'b1;
      u_if.pat_valid = 1'b1;
      u_if.pat_si = ~last_si;
      #1;
      check_eq("npat0:no_beat", u_if.shift_en, 0);
      @(posedge clk); #1;
      u_if.start = 1'b0;
      @(negedge clk);
      check_eq("npat0:done",     u_if.done, 1);
      check_eq("npat0:busy",     u_if.busy, 0);
      check_eq("npat0:shift_en", u_if.shift_en, 0);
      check_eq("npat0:fail_cnt", u_if.fail_cnt, 0);
      check_eq("npat0:ff_vld",   u_if.ff_vld, 0);
      check_eq("npat0:chain_si", u_if.chain_si, last_si);
      u_if.pat_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
